combi_sweep_seq: RTL and testbench

Sequential stimulus/check stage for the 4-input combinational circuit under test. The block walks {a,b,c,d} through all 16 input combinations in ascending order and holds each vector for a programmable number of cycles. It samples the circuit's y output once per vector, builds the observed 16-bit truth table, and compares it against a golden table captured at start. It sits directly upstream of the combinational circuit, driving its inputs, and directly downstream of it, consuming y.

---
 rtl/combi_sweep_seq_if.sv | 42 ++++
 rtl/combi_sweep_seq.sv | 166 ++++++++++++++++
 tb/tb_combi_sweep_seq.sv | 364 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/combi_sweep_seq_if.sv
// -----------------------------------------------------------------------------
// combi_sweep_seq_if
//
// Bundle of the signals between the sweep sequencer and the environment
// around it (start/golden-table control plus the 4-input circuit under test).
//
//   start        control -> sequencer  begin a sweep (level, sampled in IDLE)
//   expected     control -> sequencer  golden truth table, bit i = y for vector i
//   y            CUT     -> sequencer  output of the combinational circuit
//   a, b, c, d   sequencer -> CUT      current vector, {a,b,c,d} = index
//   busy         sequencer -> control  sweep in progress
//   done         sequencer -> control  one-cycle end-of-sweep pulse
//   truth_table  sequencer -> control  observed y per vector
//   mismatch_cnt sequencer -> control  vectors where y differed from golden
//   pass         sequencer -> control  last completed sweep had no mismatches
//
// master: the environment side. slave: the sequencer.
// -----------------------------------------------------------------------------
interface combi_sweep_seq_if;
  logic        start;
  logic [15:0] expected;
  logic        y;
  logic        a;
  logic        b;
  logic        c;
  logic        d;
  logic        busy;
  logic        done;
  logic [15:0] truth_table;
  logic [4:0]  mismatch_cnt;
  logic        pass;

  modport master (
    output start, expected, y,
    input  a, b, c, d, busy, done, truth_table, mismatch_cnt, pass
  );

  modport slave (
    input  start, expected, y,
    output a, b, c, d, busy, done, truth_table, mismatch_cnt, pass
  );
endinterface : combi_sweep_seq_if

// File: rtl/combi_sweep_seq.sv
// -----------------------------------------------------------------------------
// combi_sweep_seq
//
// Exhaustive stimulus/check stage for a 4-input combinational circuit. On an
// accepted start it captures the golden table, then walks {a,b,c,d} through
// vectors 0..15. Each vector is driven for HOLD_CYCLES cycles, then y is
// sampled for one cycle, recorded into truth_table and compared against the
// captured golden bit. After vector 15 a one-cycle done pulse is issued and
// the block returns to IDLE, holding its results until the next start.
//
// Parameters
//   HOLD_CYCLES  cycles each vector is driven before sampling (1..255)
//
// Ports
//   clk    rising-edge clock
//   rst_n  asynchronous, active-low reset
//   bus    combi_sweep_seq_if.slave (start/expected/y in, vector and results out)
// -----------------------------------------------------------------------------
module combi_sweep_seq #(
  parameter int unsigned HOLD_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  combi_sweep_seq_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    FINISH = 2'd3
  } state_t;

  // Terminal value of the 8-bit hold counter for one vector.
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);
  localparam logic [3:0] VEC_LAST  = 4'd15;

  state_t      state_q;
  state_t      state_d;

  logic [3:0]  vec_q;
  logic [7:0]  hold_cnt_q;
  logic [15:0] exp_q;
  logic [15:0] truth_table_q;
  logic [4:0]  mismatch_cnt_q;
  logic        pass_q;

  logic        hold_done;
  logic        last_vec;
  logic        y_miss;
  logic [4:0]  mismatch_next;

  assign hold_done     = (hold_cnt_q == HOLD_LAST);
  assign last_vec      = (vec_q == VEC_LAST);
  assign y_miss        = (bus.y != exp_q[vec_q]);
  // Count including the vector being sampled this cycle; pass for the final
  // vector must see its own comparison.
  assign mismatch_next = mismatch_cnt_q + 5'(y_miss);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of the order of always blocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: state_d takes a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = DRIVE;
      DRIVE:   if (hold_done) state_d = SAMPLE;
      SAMPLE:  state_d = last_vec ? FINISH : DRIVE;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.busy = 1'b0;
    bus.done = 1'b0;
    case (state_q)
      DRIVE, SAMPLE: bus.busy = 1'b1;
      FINISH: begin
        bus.busy = 1'b1;
        bus.done = 1'b1;
      end
      default: ;
    endcase
  end

  // The vector register is zero outside a sweep and only moves on the
  // SAMPLE -> DRIVE edge, so it can drive the circuit directly.
  assign {bus.a, bus.b, bus.c, bus.d} = vec_q;

  assign bus.truth_table  = truth_table_q;
  assign bus.mismatch_cnt = mismatch_cnt_q;
  assign bus.pass         = pass_q;

  // ---------------------------------------------------------------------------
  // Datapath: vector/hold counters, golden capture, results
  // ---------------------------------------------------------------------------
  // NOTE: exp_q is reset along with everything else; it is only 16 flops and
  // a defined value keeps the comparison path X-free out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_q          <= '0;
      hold_cnt_q     <= '0;
      exp_q          <= '0;
      truth_table_q  <= '0;
      mismatch_cnt_q <= '0;
      pass_q         <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // Tracking expected every IDLE cycle means the value present on the
          // start edge is the one that sticks for the whole sweep.
          exp_q      <= bus.expected;
          vec_q      <= '0;
          hold_cnt_q <= '0;
          // Results stay visible after a sweep until a new one is accepted.
          if (bus.start) begin
            truth_table_q  <= '0;
            mismatch_cnt_q <= '0;
            pass_q         <= 1'b0;
          end
        end

        DRIVE: begin
          if (!hold_done) hold_cnt_q <= hold_cnt_q + 8'd1;
        end

        SAMPLE: begin
          truth_table_q[vec_q] <= bus.y;
          mismatch_cnt_q       <= mismatch_next;
          if (last_vec) begin
            pass_q <= (mismatch_next == 5'd0);
          end else begin
            vec_q      <= vec_q + 4'd1;
            hold_cnt_q <= '0;
          end
        end

        FINISH: begin
          vec_q <= '0;
        end

        default: ;
      endcase
    end
  end

endmodule : combi_sweep_seq

// File: tb/tb_combi_sweep_seq.sv
// -----------------------------------------------------------------------------
// tb_combi_sweep_seq
//
// Two sequencer instances: HOLD_CYCLES=1 wired to the reference circuit
// y = (a&b)|(c&d), and HOLD_CYCLES=3 whose y is driven wrong during drive
// cycles and correct only in the cycle before each sampling edge. Expected
// results come from a truth-table/popcount model of the circuit and from the
// sweep timing 16*(HOLD+1) edges after the accepting edge.
// -----------------------------------------------------------------------------
module tb_combi_sweep_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        sel;        // 0: HOLD=1 instance, 1: HOLD=3 instance
  logic [15:0] expected;
  logic        y3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  combi_sweep_seq_if bus1 ();
  combi_sweep_seq_if bus3 ();

  assign bus1.start    = start & ~sel;
  assign bus3.start    = start & sel;
  assign bus1.expected = expected;
  assign bus3.expected = expected;
  assign bus1.y        = (bus1.a & bus1.b) | (bus1.c & bus1.d);
  assign bus3.y        = y3;

  combi_sweep_seq #(.HOLD_CYCLES(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  combi_sweep_seq #(.HOLD_CYCLES(3)) u_dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus3)
  );

  // Observation of the currently selected instance.
  logic [3:0]  o_vec;
  logic        o_busy, o_done, o_pass;
  logic [15:0] o_tt;
  logic [4:0]  o_mm;

  always_comb begin
    if (sel) begin
      o_vec  = {bus3.a, bus3.b, bus3.c, bus3.d};
      o_busy = bus3.busy;
      o_done = bus3.done;
      o_tt   = bus3.truth_table;
      o_mm   = bus3.mismatch_cnt;
      o_pass = bus3.pass;
    end else begin
      o_vec  = {bus1.a, bus1.b, bus1.c, bus1.d};
      o_busy = bus1.busy;
      o_done = bus1.done;
      o_tt   = bus1.truth_table;
      o_mm   = bus1.mismatch_cnt;
      o_pass = bus1.pass;
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic logic ref_y(input logic [3:0] v);
    return (v[3] & v[2]) | (v[1] & v[0]);
  endfunction

  function automatic logic [15:0] ref_table();
    logic [15:0] t;
    for (int i = 0; i < 16; i++) t[i] = ref_y(4'(i));
    return t;
  endfunction

  function automatic int popcount16(input logic [15:0] v);
    int n = 0;
    for (int i = 0; i < 16; i++) n += int'(v[i]);
    return n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // y for the HOLD=3 instance: wrong in every cycle except the one whose
  // closing edge is a sampling edge (cnt = edges since the accepting edge).
  task automatic drive_y3(input int cnt);
    logic [3:0] v;
    v  = {bus3.a, bus3.b, bus3.c, bus3.d};
    y3 = (((cnt + 1) % 4) == 0) ? ref_y(v) : ~ref_y(v);
  endtask

  // ---------------------------------------------------------------------------
  // One complete sweep on the selected instance, with optional mid-sweep
  // start pulse plus golden-table change at vector 5.
  // ---------------------------------------------------------------------------
  task automatic sweep(input string tag, input int hold, input logic [15:0] exp_tbl,
                       input bit poke);
    logic [15:0] want_tt;
    int          want_mm;
    int          cnt, budget, run_len, bad_len, bad_order;
    logic [3:0]  prev;
    logic [15:0] tt_done;
    logic [4:0]  mm_done;
    logic        pass_done;
    bit          poked;

    want_tt  = ref_table();
    want_mm  = popcount16(want_tt ^ exp_tbl);
    budget   = 16 * (hold + 1) + 20;

    sel      = (hold == 3);
    expected = exp_tbl;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    cnt      = 0;
    drive_y3(cnt);

    n_checks++;
    if (o_busy !== 1'b1 || o_vec !== 4'd0 || o_tt !== 16'h0 || o_mm !== 5'd0 || o_pass !== 1'b0) begin
      n_fail++;
      $display("FAIL %s start_clear: busy=%b vec=%0d tt=%h mm=%0d pass=%b, want 1/0/0000/0/0",
               tag, o_busy, o_vec, o_tt, o_mm, o_pass);
    end

    prev      = 4'd0;
    run_len   = 1;
    bad_len   = 0;
    bad_order = 0;
    poked     = 1'b0;
    while (o_done !== 1'b1 && cnt < budget) begin
      tick();
      cnt++;
      start = 1'b0;
      drive_y3(cnt);
      if (o_vec !== prev) begin
        if (o_vec !== 4'(prev + 4'd1)) bad_order++;
        if (run_len != hold + 1) bad_len++;
        prev    = o_vec;
        run_len = 1;
      end else begin
        run_len++;
      end
      if (poke && !poked && o_vec == 4'd5) begin
        start    = 1'b1;
        expected = 16'h0000;
        poked    = 1'b1;
      end
    end

    n_checks++;
    if (cnt != 16 * (hold + 1)) begin
      n_fail++;
      $display("FAIL %s done_edge: done after edge E0+%0d, want E0+%0d", tag, cnt, 16 * (hold + 1));
    end
    n_checks++;
    if (bad_order != 0 || prev !== 4'd15) begin
      n_fail++;
      $display("FAIL %s vec_order: %0d bad steps, last vec %0d, want 0 bad steps, last 15",
               tag, bad_order, prev);
    end
    n_checks++;
    if (bad_len != 0) begin
      n_fail++;
      $display("FAIL %s vec_hold: %0d vectors not held %0d cycles, want 0", tag, bad_len, hold + 1);
    end
    tt_done   = o_tt;
    mm_done   = o_mm;
    pass_done = o_pass;
    n_checks++;
    if (tt_done !== want_tt) begin
      n_fail++;
      $display("FAIL %s truth_table: got %h want %h", tag, tt_done, want_tt);
    end
    n_checks++;
    if (mm_done !== 5'(want_mm)) begin
      n_fail++;
      $display("FAIL %s mismatch_cnt: got %0d want %0d", tag, mm_done, want_mm);
    end
    n_checks++;
    if (pass_done !== (want_mm == 0)) begin
      n_fail++;
      $display("FAIL %s pass: got %b want %b", tag, pass_done, (want_mm == 0));
    end

    tick();
    n_checks++;
    if (o_done !== 1'b0 || o_busy !== 1'b0 || o_vec !== 4'd0 || o_tt !== want_tt ||
        o_mm !== 5'(want_mm)) begin
      n_fail++;
      $display("FAIL %s after_finish: done=%b busy=%b vec=%0d tt=%h mm=%0d, want 0/0/0/%h/%0d",
               tag, o_done, o_busy, o_vec, o_tt, o_mm, want_tt, want_mm);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_n    = 1'b0;
    start    = 1'b0;
    sel      = 1'b0;
    expected = 16'h0000;
    y3       = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({bus1.a, bus1.b, bus1.c, bus1.d, bus1.busy, bus1.done, bus1.pass} !== 7'b0 ||
        bus1.truth_table !== 16'h0 || bus1.mismatch_cnt !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_hold1: abcd=%b%b%b%b busy=%b done=%b tt=%h mm=%0d pass=%b, want all 0",
               bus1.a, bus1.b, bus1.c, bus1.d, bus1.busy, bus1.done, bus1.truth_table,
               bus1.mismatch_cnt, bus1.pass);
    end
    n_checks++;
    if ({bus3.a, bus3.b, bus3.c, bus3.d, bus3.busy, bus3.done, bus3.pass} !== 7'b0 ||
        bus3.truth_table !== 16'h0 || bus3.mismatch_cnt !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_hold3: abcd=%b%b%b%b busy=%b done=%b tt=%h mm=%0d pass=%b, want all 0",
               bus3.a, bus3.b, bus3.c, bus3.d, bus3.busy, bus3.done, bus3.truth_table,
               bus3.mismatch_cnt, bus3.pass);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_golden();
    sweep("golden", 1, 16'hF888, 1'b0);
  endtask

  task automatic test_single_mismatch();
    sweep("single_mismatch", 1, 16'hF889, 1'b0);
  endtask

  // Results must persist in IDLE, then clear only when the next start lands.
  task automatic test_back_to_back();
    sweep("b2b_first", 1, 16'hF889, 1'b0);
    repeat (5) tick();
    n_checks++;
    if (o_tt !== 16'hF888 || o_mm !== 5'd1 || o_pass !== 1'b0 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_hold: tt=%h mm=%0d pass=%b busy=%b, want f888/1/0/0",
               o_tt, o_mm, o_pass, o_busy);
    end
    sweep("b2b_second", 1, 16'hF888, 1'b0);
  endtask

  task automatic test_start_mid_sweep();
    sweep("start_mid_sweep", 1, 16'hF888, 1'b1);
  endtask

  // Start held high across FINISH relaunches from IDLE one edge later.
  task automatic test_start_held();
    int cnt;
    sel      = 1'b0;
    expected = 16'hF888;
    start    = 1'b1;
    tick();
    cnt = 0;
    while (o_done !== 1'b1 && cnt < 60) begin
      tick();
      cnt++;
    end
    n_checks++;
    if (cnt != 32) begin
      n_fail++;
      $display("FAIL held_done_edge: done after edge E0+%0d, want E0+32", cnt);
    end
    tick();
    n_checks++;
    if (o_busy !== 1'b0 || o_tt !== 16'hF888) begin
      n_fail++;
      $display("FAIL held_idle: busy=%b tt=%h, want 0/f888", o_busy, o_tt);
    end
    tick();
    n_checks++;
    if (o_busy !== 1'b1 || o_vec !== 4'd0 || o_tt !== 16'h0 || o_mm !== 5'd0) begin
      n_fail++;
      $display("FAIL held_restart: busy=%b vec=%0d tt=%h mm=%0d, want 1/0/0000/0",
               o_busy, o_vec, o_tt, o_mm);
    end
    start = 1'b0;
    cnt   = 0;
    while (o_done !== 1'b1 && cnt < 60) begin
      tick();
      cnt++;
    end
    n_checks++;
    if (cnt != 32 || o_tt !== 16'hF888 || o_pass !== 1'b1) begin
      n_fail++;
      $display("FAIL held_second: done at E0+%0d tt=%h pass=%b, want E0+32/f888/1", cnt, o_tt, o_pass);
    end
    tick();
  endtask

  task automatic test_reset_mid_sweep();
    int cnt;
    sel      = 1'b0;
    expected = 16'hF888;
    start    = 1'b1;
    tick();
    start = 1'b0;
    cnt   = 0;
    while (o_vec !== 4'd7 && cnt < 60) begin
      tick();
      cnt++;
    end
    n_checks++;
    if (o_vec !== 4'd7 || o_tt === 16'h0) begin
      n_fail++;
      $display("FAIL rst_mid_reach: vec=%0d tt=%h, want vec 7 with vector 3 recorded", o_vec, o_tt);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (o_vec !== 4'd0 || o_busy !== 1'b0 || o_done !== 1'b0 || o_tt !== 16'h0 ||
        o_mm !== 5'd0 || o_pass !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_async: vec=%0d busy=%b done=%b tt=%h mm=%0d pass=%b, want all 0",
               o_vec, o_busy, o_done, o_tt, o_mm, o_pass);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    sweep("after_reset", 1, 16'hF888, 1'b0);
  endtask

  task automatic test_long_hold();
    sweep("long_hold", 3, 16'hF888, 1'b0);
  endtask

  task automatic test_random();
    logic [15:0] tbl;
    for (int k = 0; k < 4; k++) begin
      tbl = 16'($urandom);
      sweep($sformatf("random%0d", k), ((k % 2) == 1) ? 3 : 1, tbl, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_golden();
    test_single_mismatch();
    test_back_to_back();
    test_start_mid_sweep();
    test_start_held();
    test_reset_mid_sweep();
    test_long_hold();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_combi_sweep_seq
